// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scanner for the level-meter 7-segment readout.
// Steps through NUM_DIGITS BCD digits, feeds the shared decoder, registers its
// segment pattern and drives common-anode enables with a dead gap per slot.
// Loaded values are double-buffered and take effect at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned DEAD_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  input  logic                    lz_en,
  input  logic [7:0]              dec_seg,
  output logic [3:0]              dec_data,
  output logic                    dec_blank,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // DARK: scan disabled (or just reset); GAP: dead time; SHOW: anode on
  typedef enum logic [1:0] {
    ST_DARK,
    ST_GAP,
    ST_SHOW
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    slot_end;
  logic                    frame_end;
  logic [VAL_W-1:0]        shadow;
  logic [VAL_W-1:0]        pending;
  logic                    pending_valid;
  logic                    apply_now;
  logic                    above_nz;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [7:0]              seg_nxt;

  // Lookahead of slot counter and digit index; disabled scan parks at digit 0, cycle 0
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = en && slot_end && (idx == IDX_LAST);
    cnt_nxt   = '0;
    idx_nxt   = '0;
    if (en) begin
      if (slot_end) begin
        cnt_nxt = '0;
        idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
        idx_nxt = idx;
      end
    end
  end

  // Slot counter and digit index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  // Scan phase state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_DARK;
    end else begin
      state <= state_nxt;
    end
  end

  // Phase transitions, judged on the counter value the next edge will load
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_DARK;
    end else begin
      case (state)
        ST_DARK, ST_GAP: state_nxt = (cnt_nxt == CNT_SHOW) ? ST_SHOW : ST_GAP;
        ST_SHOW:         state_nxt = slot_end ? ST_GAP : ST_SHOW;
        default:         state_nxt = ST_DARK;
      endcase
    end
  end

  // Anode and segment drive for the next cycle (computed ahead so both are flop outputs)
  always_comb begin
    anode_nxt = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((state_nxt == ST_SHOW) && (idx_nxt == IDX_W'(i))) begin
        anode_nxt[i] = 1'b0;
      end
    end
    seg_nxt = en ? dec_seg : 8'hFF;
  end

  // Registered display outputs and frame boundary pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      anode      <= '1;
      seg_out    <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_nxt;
      seg_out    <= seg_nxt;
      frame_done <= frame_end;
    end
  end

  // Shadow is updated only at a frame boundary or while the display is dark
  assign apply_now = !en || frame_end;

  // Double buffer: a load on an apply edge bypasses the pending buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (apply_now) begin
      if (load) begin
        pending <= value_bcd;
        shadow  <= value_bcd;
      end else if (pending_valid) begin
        shadow <= pending;
      end
      pending_valid <= 1'b0;
    end else if (load) begin
      pending       <= value_bcd;
      pending_valid <= 1'b1;
    end
  end

  // Decoder drive: current digit code and leading-zero blank request
  always_comb begin
    dec_data = '0;
    above_nz = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        dec_data = shadow[4*i +: 4];
      end
      if ((IDX_W'(i) >= idx) && (shadow[4*i +: 4] != 4'd0)) begin
        above_nz = 1'b1;
      end
    end
    dec_blank = lz_en && (idx != '0) && !above_nz;
  end

endmodule
